fwd_hazard_ctrl: RTL and testbench

Controller that sequences operand selection for the execute stage.
- Keeps a shadow pipeline (EX, MEM, WB slots) of destination-register info for in-flight instructions.
- Drives ALUsrc1/ALUsrc2 so that EX takes prev_ALU or prev_mem instead of stale register-file data.
- Drives flag_src so that EX takes mem_flags when flags are restored from memory.
- Detects load-use hazards and asserts a one-cycle stall, inserting a bubble.

---
 rtl/core_pkg.sv | 23 ++
 rtl/fwd_hazard_ctrl_if.sv | 32 +++
 rtl/fwd_select.sv | 28 ++
 rtl/fwd_hazard_ctrl.sv | 75 +++++++
 tb/tb_fwd_hazard_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the execute-stage forwarding/hazard controller.
package core_pkg;

   localparam int REG_W = 3;

   localparam logic [1:0] ALU_SRC_REG      = 2'b00;
   localparam logic [1:0] ALU_SRC_PREV_ALU = 2'b01;
   localparam logic [1:0] ALU_SRC_PREV_MEM = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      logic             we;
      logic             ld;
      logic             flags_ld;
      logic [REG_W-1:0] src1;
      logic             src1_used;
      logic [REG_W-1:0] src2;
      logic             src2_used;
      logic             flags_rd;
   } slot_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side request and operand-select response bundle of the controller.
interface fwd_hazard_ctrl_if;
   import core_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_src1;
   logic             id_src1_used;
   logic [REG_W-1:0] id_src2;
   logic             id_src2_used;
   logic [REG_W-1:0] id_dst;
   logic             id_we;
   logic             id_ld;
   logic             id_flags_rd;
   logic             id_flags_ld;
   logic             flush;
   logic [1:0]       alu_src1;
   logic [1:0]       alu_src2;
   logic             flag_src;
   logic             stall;

   modport master (
      output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
             id_dst, id_we, id_ld, id_flags_rd, id_flags_ld, flush,
      input  alu_src1, alu_src2, flag_src, stall
   );

   modport slave (
      input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
             id_dst, id_we, id_ld, id_flags_rd, id_flags_ld, flush,
      output alu_src1, alu_src2, flag_src, stall
   );
endinterface

// File: rtl/fwd_select.sv
// Operand source select for one EX operand: MEM (prev_ALU) beats WB (prev_mem) beats register file.
module fwd_select
   import core_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             used,
   input  slot_t            mem_slot,
   input  slot_t            wb_slot,
   output logic [1:0]       sel
);
   logic mem_hit;
   logic wb_hit;
   logic unused_fields;

   // A load sitting in MEM has no data on prev_ALU yet, so it never forwards from there.
   assign mem_hit = used && mem_slot.valid && mem_slot.we && !mem_slot.ld && (mem_slot.dst == src);
   assign wb_hit  = used && wb_slot.valid && wb_slot.we && (wb_slot.dst == src);

   always_comb begin
      sel = ALU_SRC_REG;
      if (mem_hit)
         sel = ALU_SRC_PREV_ALU;
      else if (wb_hit)
         sel = ALU_SRC_PREV_MEM;
   end

   assign unused_fields = ^{mem_slot, wb_slot};
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Shadow EX/MEM/WB pipeline of destination info driving forwarding selects, flag source and load-use stall.
module fwd_hazard_ctrl
   import core_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   fwd_hazard_ctrl_if.slave   bus
);
   slot_t ex_q,  ex_d;
   slot_t mem_q, mem_d;
   slot_t wb_q,  wb_d;
   slot_t id_slot;
   logic  src1_hit;
   logic  src2_hit;
   logic  stall_raw;

   always_comb begin
      id_slot           = '0;
      id_slot.valid     = 1'b1;
      id_slot.dst       = bus.id_dst;
      id_slot.we        = bus.id_we;
      id_slot.ld        = bus.id_ld;
      id_slot.flags_ld  = bus.id_flags_ld;
      id_slot.src1      = bus.id_src1;
      id_slot.src1_used = bus.id_src1_used;
      id_slot.src2      = bus.id_src2;
      id_slot.src2_used = bus.id_src2_used;
      id_slot.flags_rd  = bus.id_flags_rd;
   end

   assign src1_hit  = bus.id_src1_used && (bus.id_src1 == ex_q.dst);
   assign src2_hit  = bus.id_src2_used && (bus.id_src2 == ex_q.dst);
   assign stall_raw = bus.id_valid && ex_q.valid && ex_q.we && ex_q.ld && (src1_hit || src2_hit);

   // Flush squashes the decode instruction anyway, so a stall on it would be pointless.
   assign bus.stall = stall_raw && !bus.flush;

   always_comb begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (bus.id_valid && !bus.stall && !bus.flush)
         ex_d = id_slot;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   fwd_select u_sel1 (
      .src      (ex_q.src1),
      .used     (ex_q.valid && ex_q.src1_used),
      .mem_slot (mem_q),
      .wb_slot  (wb_q),
      .sel      (bus.alu_src1)
   );

   fwd_select u_sel2 (
      .src      (ex_q.src2),
      .used     (ex_q.valid && ex_q.src2_used),
      .mem_slot (mem_q),
      .wb_slot  (wb_q),
      .sel      (bus.alu_src2)
   );

   assign bus.flag_src = ex_q.valid && ex_q.flags_rd && mem_q.valid && mem_q.flags_ld;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl with hand-computed expected selects, stall and flag source.
module tb_fwd_hazard_ctrl;
   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   fwd_hazard_ctrl_if bus ();

   fwd_hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, got);
      end
   endtask

   task automatic issue(input logic v, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] d,
                        input logic we, input logic ld, input logic frd, input logic fld);
      bus.id_valid     = v;
      bus.id_src1      = s1;
      bus.id_src1_used = u1;
      bus.id_src2      = s2;
      bus.id_src2_used = u2;
      bus.id_dst       = d;
      bus.id_we        = we;
      bus.id_ld        = ld;
      bus.id_flags_rd  = frd;
      bus.id_flags_ld  = fld;
      #1;
   endtask

   task automatic idle();
      issue(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      bus.flush    = 1'b0;
      idle();
      tick();
      tick();
      check("rst_alu_src1", {30'd0, bus.alu_src1}, 32'd0);
      check("rst_alu_src2", {30'd0, bus.alu_src2}, 32'd0);
      check("rst_flag_src", {31'd0, bus.flag_src}, 32'd0);
      check("rst_stall",    {31'd0, bus.stall},    32'd0);
      rst = 1'b0;

      // ADD R1 <- R7,R7 ; ADD R2 <- R1,R3
      issue(1, 3'd7, 1, 3'd7, 1, 3'd1, 1, 0, 0, 0);
      tick();
      issue(1, 3'd1, 1, 3'd3, 1, 3'd2, 1, 0, 0, 0);
      check("back2back_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      check("back2back_src1", {30'd0, bus.alu_src1}, 32'd1);
      check("back2back_src2", {30'd0, bus.alu_src2}, 32'd0);

      // R1 producer, unrelated ADD R0, consumer src1=R5 src2=R1
      issue(1, 3'd7, 1, 3'd7, 1, 3'd1, 1, 0, 0, 0);
      tick();
      issue(1, 3'd7, 1, 3'd7, 1, 3'd0, 1, 0, 0, 0);
      tick();
      issue(1, 3'd5, 1, 3'd1, 1, 3'd3, 1, 0, 0, 0);
      tick();
      check("gap1_src1", {30'd0, bus.alu_src1}, 32'd0);
      check("gap1_src2", {30'd0, bus.alu_src2}, 32'd2);

      // LDD R4 ; ADD R5 <- R4,R4 : one stall, bubble, then prev_mem on both
      issue(1, 3'd7, 0, 3'd7, 0, 3'd4, 1, 1, 0, 0);
      tick();
      issue(1, 3'd4, 1, 3'd4, 1, 3'd5, 1, 0, 0, 0);
      check("lu_stall_on", {31'd0, bus.stall}, 32'd1);
      tick();
      check("lu_bubble_src1", {30'd0, bus.alu_src1}, 32'd0);
      check("lu_bubble_src2", {30'd0, bus.alu_src2}, 32'd0);
      check("lu_stall_off", {31'd0, bus.stall}, 32'd0);
      tick();
      check("lu_fwd_src1", {30'd0, bus.alu_src1}, 32'd2);
      check("lu_fwd_src2", {30'd0, bus.alu_src2}, 32'd2);

      // Two R6 producers back to back, consumer of R6: MEM wins
      issue(1, 3'd7, 1, 3'd7, 1, 3'd6, 1, 0, 0, 0);
      tick();
      issue(1, 3'd7, 1, 3'd7, 1, 3'd6, 1, 0, 0, 0);
      tick();
      issue(1, 3'd6, 1, 3'd0, 0, 3'd1, 1, 0, 0, 0);
      tick();
      check("prio_src1", {30'd0, bus.alu_src1}, 32'd1);
      check("prio_src2", {30'd0, bus.alu_src2}, 32'd0);

      // Non-writing instruction with dst R3, consumer of R3: no forward
      issue(1, 3'd7, 1, 3'd7, 1, 3'd3, 0, 0, 0, 0);
      tick();
      issue(1, 3'd3, 1, 3'd3, 1, 3'd2, 1, 0, 0, 0);
      tick();
      check("nowe_src1", {30'd0, bus.alu_src1}, 32'd0);
      check("nowe_src2", {30'd0, bus.alu_src2}, 32'd0);

      // RTI then flags-reading ADD
      issue(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1);
      tick();
      issue(1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 0, 1, 0);
      tick();
      check("flags_on", {31'd0, bus.flag_src}, 32'd1);
      idle();
      tick();
      check("flags_off", {31'd0, bus.flag_src}, 32'd0);

      // Load-use hazard with simultaneous flush
      issue(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0);
      tick();
      issue(1, 3'd2, 1, 3'd0, 0, 3'd5, 1, 0, 1, 0);
      bus.flush = 1'b1;
      #1;
      check("flush_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      bus.flush = 1'b0;
      idle();
      check("flush_bubble_src1", {30'd0, bus.alu_src1}, 32'd0);
      check("flush_bubble_flag", {31'd0, bus.flag_src}, 32'd0);
      tick();
      tick();

      // Reset asserted during a stall
      issue(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0, 0);
      tick();
      issue(1, 3'd0, 0, 3'd3, 1, 3'd4, 1, 0, 0, 0);
      check("rststall_on", {31'd0, bus.stall}, 32'd1);
      rst = 1'b1;
      tick();
      check("rststall_stall", {31'd0, bus.stall},    32'd0);
      check("rststall_src1",  {30'd0, bus.alu_src1}, 32'd0);
      check("rststall_src2",  {30'd0, bus.alu_src2}, 32'd0);
      check("rststall_flag",  {31'd0, bus.flag_src}, 32'd0);
      rst = 1'b0;
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
